// File: rtl/odu_chan_ctrl.sv
// Channel control for the ODU traffic generator: shadow enable/type words applied
// atomically on START, explicit STOP, and sticky W1C per-channel error capture.
module odu_chan_ctrl #(
  parameter int DATA_WIDTH_CFG = 16,
  parameter int ADDR_WIDTH_CFG = 6,
  parameter int NUM_CH         = 80
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_n_cs,
  input  logic                      cfg_n_we,
  input  logic                      cfg_n_oe,
  input  logic [ADDR_WIDTH_CFG-1:0] cfg_addr,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_din,
  output logic [DATA_WIDTH_CFG-1:0] cfg_dout,
  output logic [NUM_CH-1:0]         enable_chid,
  output logic [NUM_CH-1:0]         type_chid,
  output logic                      start,
  output logic                      err_irq,
  input  logic [NUM_CH-1:0]         i_error_chid
);
  localparam int DW = DATA_WIDTH_CFG;
  localparam int NW = (NUM_CH + DW - 1) / DW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_STOP = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] en_sh_q, en_sh_d, ty_sh_q, ty_sh_d;
  logic [NUM_CH-1:0] en_act_q, en_act_d, ty_act_q, ty_act_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d, masked;
  logic [DW-1:0]     cnt_q, cnt_d, dout_q, dout_d, rdata;
  logic              dirty_q, dirty_d;
  logic              wr, rd, ctrl_wr, start_cmd, stop_cmd, clr_cmd, shadow_wr;
  logic              run, load, halt;
  logic [NW-1:0]     en_sel, ty_sel, er_sel;

  assign wr        = !cfg_n_cs && !cfg_n_we;
  assign rd        = !cfg_n_cs && !cfg_n_oe && cfg_n_we;
  assign ctrl_wr   = wr && (cfg_addr == '0);
  assign start_cmd = ctrl_wr && cfg_din[0];
  assign stop_cmd  = ctrl_wr && cfg_din[1];
  assign clr_cmd   = ctrl_wr && cfg_din[2];

  always_comb begin
    en_sel = '0;
    ty_sel = '0;
    er_sel = '0;
    for (int k = 0; k < NW; k++) begin
      en_sel[k] = (cfg_addr == ADDR_WIDTH_CFG'(8 + k));
      ty_sel[k] = (cfg_addr == ADDR_WIDTH_CFG'(16 + k));
      er_sel[k] = (cfg_addr == ADDR_WIDTH_CFG'(24 + k));
    end
  end

  assign shadow_wr = wr && ((|en_sel) || (|ty_sel));

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state; STOP has priority over START in RUN, the pair is dropped in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_cmd && !stop_cmd) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (stop_cmd) state_d = S_STOP;
               else if (start_cmd) state_d = S_LOAD;
      S_STOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run   = (state_q == S_RUN);
    load  = (state_q == S_LOAD);
    halt  = (state_q == S_STOP);
    start = run;
  end

  always_comb begin
    en_sh_d = en_sh_q;
    ty_sh_d = ty_sh_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && en_sel[i / DW]) en_sh_d[i] = cfg_din[i % DW];
      if (wr && ty_sel[i / DW]) ty_sh_d[i] = cfg_din[i % DW];
    end
    // A write landing during LOAD misses the copy, so it must leave the shadow dirty
    if (shadow_wr && (run || load)) dirty_d = 1'b1;
    else if (load)                  dirty_d = 1'b0;
    else                            dirty_d = dirty_q;
    en_act_d = load ? en_sh_q : (halt ? '0 : en_act_q);
    ty_act_d = load ? ty_sh_q : ty_act_q;
  end

  assign masked = run ? (i_error_chid & en_act_q) : '0;

  always_comb begin
    sticky_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sticky_d[i] = (clr_cmd ? 1'b0 : (sticky_q[i] & ~(wr && er_sel[i / DW] && cfg_din[i % DW])))
                    | masked[i];
    end
    cnt_d = clr_cmd ? '0 : cnt_q;
    if (|masked) begin
      if (clr_cmd)      cnt_d = DW'(1);
      else if (~&cnt_q) cnt_d = cnt_q + DW'(1);
    end
  end

  always_comb begin
    rdata = '0;
    if (cfg_addr == ADDR_WIDTH_CFG'(1)) begin
      rdata[1:0] = state_q;
      rdata[2]   = err_irq;
      rdata[3]   = dirty_q;
    end
    if (cfg_addr == ADDR_WIDTH_CFG'(2)) rdata = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_sel[i / DW]) rdata[i % DW] = en_sh_q[i];
      if (ty_sel[i / DW]) rdata[i % DW] = ty_sh_q[i];
      if (er_sel[i / DW]) rdata[i % DW] = sticky_q[i];
    end
    dout_d = rd ? rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sh_q  <= '0;
      ty_sh_q  <= '0;
      en_act_q <= '0;
      ty_act_q <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      dirty_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      en_sh_q  <= en_sh_d;
      ty_sh_q  <= ty_sh_d;
      en_act_q <= en_act_d;
      ty_act_q <= ty_act_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      dirty_q  <= dirty_d;
      dout_q   <= dout_d;
    end
  end

  assign cfg_dout    = dout_q;
  assign enable_chid = en_act_q;
  assign type_chid   = ty_act_q;
  assign err_irq     = |sticky_q;
endmodule
